// File: rtl/ctrl_branch_unit.sv
// ctrl_branch_unit: EX-stage branch/jump/call/return resolution with a return-address stack
module ctrl_branch_unit #(
    parameter int PROG_CTR_WID    = 10,
    parameter int RET_STACK_DEPTH = 4,
    parameter int RET_PTR_WID     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_ID,
    input  logic [PROG_CTR_WID-1:0] prog_ctr_ID,
    input  logic [2:0]              br_op_ID,
    input  logic [PROG_CTR_WID-1:0] br_target_ID,
    input  logic                    flag_zero_EX,
    input  logic                    flag_carry_EX,
    output logic                    branch_taken_EX,
    output logic [PROG_CTR_WID-1:0] nxt_prog_ctr_EX,
    output logic                    flush_ID,
    output logic                    ret_stack_empty,
    output logic                    ret_stack_full,
    output logic                    stack_err
);
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BZ   = 3'b010;
    localparam logic [2:0] OP_BNZ  = 3'b011;
    localparam logic [2:0] OP_BC   = 3'b100;
    localparam logic [2:0] OP_BNC  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;
    localparam logic [RET_PTR_WID:0]    CNT_ONE = 1;
    localparam logic [RET_PTR_WID:0]    CNT_MAX = (RET_PTR_WID+1)'(RET_STACK_DEPTH);
    localparam logic [PROG_CTR_WID-1:0] PC_ONE  = 1;

    logic                    valid_ex;
    logic [2:0]              op_ex;
    logic [PROG_CTR_WID-1:0] pc_ex;
    logic [PROG_CTR_WID-1:0] target_ex;
    logic [PROG_CTR_WID-1:0] stack [RET_STACK_DEPTH];
    logic [RET_PTR_WID:0]    cnt;
    logic                    cond;
    logic                    push;
    logic                    pop;
    logic                    err_set;
    logic [PROG_CTR_WID-1:0] top;

    assign ret_stack_empty = (cnt == '0);
    assign ret_stack_full  = (cnt == CNT_MAX);
    assign top             = stack[RET_PTR_WID'(cnt - CNT_ONE)];
    assign flush_ID        = branch_taken_EX;

    // Condition evaluation and redirect target for the op sitting in EX
    always_comb begin
        cond = (op_ex == OP_JMP || op_ex == OP_CALL) ? 1'b1 :
               (op_ex == OP_BZ)  ? flag_zero_EX :
               (op_ex == OP_BNZ) ? ~flag_zero_EX :
               (op_ex == OP_BC)  ? flag_carry_EX :
               (op_ex == OP_BNC) ? ~flag_carry_EX :
               (op_ex == OP_RET) ? ~ret_stack_empty : 1'b0;
        branch_taken_EX = valid_ex & cond;
        nxt_prog_ctr_EX = !branch_taken_EX ? '0 : (op_ex == OP_RET) ? top : target_ex;
        push    = branch_taken_EX & (op_ex == OP_CALL) & ~ret_stack_full;
        pop     = branch_taken_EX & (op_ex == OP_RET);
        err_set = valid_ex & (((op_ex == OP_CALL) & ret_stack_full) |
                              ((op_ex == OP_RET) & ret_stack_empty));
    end

    // ID->EX pipeline register; a taken branch squashes the instruction behind it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_ex  <= 1'b0;
            op_ex     <= OP_NONE;
            pc_ex     <= '0;
            target_ex <= '0;
        end else begin
            valid_ex  <= valid_ID & ~branch_taken_EX;
            op_ex     <= br_op_ID;
            pc_ex     <= prog_ctr_ID;
            target_ex <= br_target_ID;
        end
    end

    // Return-address stack push/pop and sticky overflow/underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < RET_STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            if (push) begin
                stack[RET_PTR_WID'(cnt)] <= pc_ex + PC_ONE;
                cnt <= cnt + CNT_ONE;
            end else if (pop) begin
                cnt <= cnt - CNT_ONE;
            end
            if (err_set) stack_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_branch_unit.sv
// tb_ctrl_branch_unit: directed and random checks of ctrl_branch_unit against a queue-based model
module tb_ctrl_branch_unit;
    localparam int W = 10;
    localparam int NONE = 0, JMP = 1, BZ = 2, BNZ = 3, BC = 4, BNC = 5, CALL = 6, RET = 7;

    logic         clk = 0;
    logic         reset = 1;
    logic         valid_ID = 0;
    logic [W-1:0] prog_ctr_ID = 0;
    logic [2:0]   br_op_ID = 0;
    logic [W-1:0] br_target_ID = 0;
    logic         flag_zero_EX = 0;
    logic         flag_carry_EX = 0;
    logic         branch_taken_EX;
    logic [W-1:0] nxt_prog_ctr_EX;
    logic         flush_ID;
    logic         ret_stack_empty;
    logic         ret_stack_full;
    logic         stack_err;

    ctrl_branch_unit dut (
        .clk(clk), .reset(reset), .valid_ID(valid_ID), .prog_ctr_ID(prog_ctr_ID),
        .br_op_ID(br_op_ID), .br_target_ID(br_target_ID),
        .flag_zero_EX(flag_zero_EX), .flag_carry_EX(flag_carry_EX),
        .branch_taken_EX(branch_taken_EX), .nxt_prog_ctr_EX(nxt_prog_ctr_EX),
        .flush_ID(flush_ID), .ret_stack_empty(ret_stack_empty),
        .ret_stack_full(ret_stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction held in EX and the return stack as a queue
    bit m_known = 0;
    bit m_valid = 0;
    int m_op = 0, m_pc = 0, m_tgt = 0;
    int q[$];
    bit m_err = 0;
    bit e_taken;
    int e_nxt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void predict();
        bit c;
        case (m_op)
            JMP, CALL: c = 1;
            BZ:  c = flag_zero_EX;
            BNZ: c = !flag_zero_EX;
            BC:  c = flag_carry_EX;
            BNC: c = !flag_carry_EX;
            RET: c = q.size() > 0;
            default: c = 0;
        endcase
        e_taken = m_valid && c;
        e_nxt = !e_taken ? 0 : (m_op == RET) ? q[$] : m_tgt;
    endfunction

    // Present one cycle of inputs and compare all outputs with the model
    task automatic drive(input bit v, input int pc, input int op, input int tgt, input bit z, input bit c);
        valid_ID = v; prog_ctr_ID = W'(pc); br_op_ID = 3'(op); br_target_ID = W'(tgt);
        flag_zero_EX = z; flag_carry_EX = c;
        #1;
        predict();
        if (m_known) begin
            chk("taken", 32'(branch_taken_EX), 32'(e_taken));
            chk("nxt", 32'(nxt_prog_ctr_EX), 32'(e_nxt));
            chk("flush", 32'(flush_ID), 32'(e_taken));
            chk("empty", 32'(ret_stack_empty), 32'(q.size() == 0));
            chk("full", 32'(ret_stack_full), 32'(q.size() == 4));
            chk("err", 32'(stack_err), 32'(m_err));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_op = 0; m_pc = 0; m_tgt = 0; q.delete(); m_err = 0;
        end else begin
            if (m_valid && m_op == CALL) begin
                if (q.size() < 4) q.push_back((m_pc + 1) % 1024); else m_err = 1;
            end
            if (m_valid && m_op == RET) begin
                if (q.size() > 0) void'(q.pop_back()); else m_err = 1;
            end
            m_valid = valid_ID && !e_taken;
            m_op = int'(br_op_ID); m_pc = int'(prog_ctr_ID); m_tgt = int'(br_target_ID);
        end
        m_known = 1;
        @(negedge clk);
    endtask

    task automatic idle(input bit z, input bit c);
        drive(0, 0, NONE, 0, z, c);
    endtask

    int ret_exp[4] = '{'h032, 'h022, 'h012, 'h002};

    initial begin
        @(negedge clk);
        reset = 1;
        drive(1, 'h000, JMP, 'h080, 0, 0); tick();
        drive(1, 'h000, JMP, 'h080, 0, 0);
        chk("rst_taken", 32'(branch_taken_EX), 0);
        chk("rst_nxt", 32'(nxt_prog_ctr_EX), 0);
        chk("rst_empty", 32'(ret_stack_empty), 1);
        tick();
        reset = 0;
        drive(1, 'h010, JMP, 'h080, 0, 0);
        chk("rst2_taken", 32'(branch_taken_EX), 0);
        tick();
        drive(1, 'h011, JMP, 'h200, 0, 0);
        chk("jmp_taken", 32'(branch_taken_EX), 1);
        chk("jmp_nxt", 32'(nxt_prog_ctr_EX), 'h080);
        chk("jmp_flush", 32'(flush_ID), 1);
        tick();
        idle(0, 0);
        chk("squash_taken", 32'(branch_taken_EX), 0);
        tick();
        drive(1, 'h020, BZ, 'h040, 0, 0); tick();
        idle(0, 0);
        chk("bz0_taken", 32'(branch_taken_EX), 0);
        chk("bz0_nxt", 32'(nxt_prog_ctr_EX), 0);
        tick();
        drive(1, 'h021, BZ, 'h040, 0, 0); tick();
        idle(1, 0);
        chk("bz1_taken", 32'(branch_taken_EX), 1);
        chk("bz1_nxt", 32'(nxt_prog_ctr_EX), 'h040);
        tick();
        drive(1, 'h022, BNC, 'h040, 0, 0); tick();
        idle(0, 1);
        chk("bnc_taken", 32'(branch_taken_EX), 0);
        tick();
        drive(1, 'h3FF, CALL, 'h020, 0, 0); tick();
        idle(0, 0);
        chk("call_taken", 32'(branch_taken_EX), 1);
        chk("call_nxt", 32'(nxt_prog_ctr_EX), 'h020);
        tick();
        idle(0, 0);
        chk("call_empty", 32'(ret_stack_empty), 0);
        tick();
        drive(1, 'h025, RET, 'h000, 0, 0); tick();
        idle(0, 0);
        chk("ret_taken", 32'(branch_taken_EX), 1);
        chk("ret_wrap_nxt", 32'(nxt_prog_ctr_EX), 'h000);
        tick();
        idle(0, 0);
        chk("ret_empty", 32'(ret_stack_empty), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 16 * i + 1, CALL, 'h100, 0, 0); tick();
            idle(0, 0); tick();
        end
        idle(0, 0);
        chk("ovf_full", 32'(ret_stack_full), 1);
        tick();
        drive(1, 'h041, CALL, 'h100, 0, 0); tick();
        idle(0, 0);
        chk("ovf_taken", 32'(branch_taken_EX), 1);
        chk("ovf_nxt", 32'(nxt_prog_ctr_EX), 'h100);
        tick();
        idle(0, 0);
        chk("ovf_err", 32'(stack_err), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h050, RET, 0, 0, 0); tick();
            idle(0, 0);
            chk("ovf_ret_nxt", 32'(nxt_prog_ctr_EX), 32'(ret_exp[i]));
            tick();
        end
        drive(1, 'h060, RET, 0, 0, 0); tick();
        idle(0, 0);
        chk("unf_taken", 32'(branch_taken_EX), 0);
        chk("unf_flush", 32'(flush_ID), 0);
        tick();
        idle(0, 0);
        chk("unf_err", 32'(stack_err), 1);
        chk("unf_empty", 32'(ret_stack_empty), 1);
        tick();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        reset = 1;
        idle(0, 0); tick();
        reset = 0;
        idle(0, 0);
        chk("final_err_clear", 32'(stack_err), 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
